// File: rtl/layer2_bias_act.sv
// layer2_bias_act: per-neuron bias add, saturate and ReLU with a registered output; define ARGMAX_EN for frame argmax
module layer2_bias_act #(
  parameter int NUM_NEURONS = 15,
  parameter int ACC_W = 32,
  parameter int SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [ACC_W-1:0] acc_data,
  output logic [6:0]       bias_addr,
  input  logic [15:0]      bias_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [6:0]       out_idx,
  output logic             out_last,
  output logic             frame_done,
  output logic [6:0]       max_idx,
  output logic             max_valid
);
  localparam int IW = $clog2(NUM_NEURONS);
  logic [IW-1:0] idx;
  logic signed [ACC_W-1:0] s;
  logic [ACC_W:0] sum;
  logic [15:0] act;
  logic accept;
  logic last_n;
  assign s = $signed(acc_data) >>> SHIFT;
  assign sum = {s[ACC_W-1], s} + {{(ACC_W-15){bias_data[15]}}, bias_data};
  // negative sums fold the low clamp and ReLU into a single zero
  assign act = sum[ACC_W] ? 16'h0000 : (|sum[ACC_W-1:15]) ? 16'h7fff : sum[15:0];
  assign acc_ready = !out_valid || out_ready;
  assign accept = acc_valid && acc_ready;
  assign last_n = idx == IW'(NUM_NEURONS - 1);
  assign bias_addr = 7'(idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (accept) begin
        out_data <= act;
        out_idx <= 7'(idx);
        out_last <= last_n;
        out_valid <= 1'b1;
        idx <= last_n ? '0 : idx + IW'(1);
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef ARGMAX_EN
  logic [15:0] run_max;
  logic [IW-1:0] run_idx;
  logic take;
  // strict compare keeps the lower index on ties
  assign take = idx == '0 || act > run_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_max <= '0;
      run_idx <= '0;
      max_idx <= '0;
      max_valid <= 1'b0;
    end else if (accept) begin
      if (take) begin
        run_max <= act;
        run_idx <= idx;
      end
      if (last_n) begin
        max_idx <= 7'(take ? idx : run_idx);
        max_valid <= 1'b1;
      end else if (idx == '0) max_valid <= 1'b0;
    end
`else
  assign max_idx = '0;
  assign max_valid = 1'b0;
`endif
endmodule

// File: tb/tb_layer2_bias_act.sv
// tb_layer2_bias_act: directed vector table, handshake corner sequences and random traffic against a reference model
module tb_layer2_bias_act;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_valid = 1'b0;
  logic acc_ready;
  logic [31:0] acc_data = '0;
  logic [6:0] bias_addr;
  logic [15:0] bias_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;
  logic [6:0] out_idx;
  logic out_last;
  logic frame_done;
  logic [6:0] max_idx;
  logic max_valid;
  logic [15:0] bias_mem [15];
  int n_cmp = 0;
  int n_err = 0;
  int exp_idx;
  logic m_valid, m_last, m_fd, m_max_valid;
  logic [15:0] m_data;
  int m_idx, m_max_idx;
  int fr [15];
  typedef struct {
    logic [31:0] acc;
    logic [15:0] bias;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;
  assign bias_data = (bias_addr < 7'd15) ? bias_mem[bias_addr[3:0]] : 16'h0000;

  layer2_bias_act dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .bias_addr(bias_addr), .bias_data(bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .frame_done(frame_done),
    .max_idx(max_idx), .max_valid(max_valid)
  );

  function automatic logic [15:0] ref_act(input logic [31:0] acc, input logic [15:0] b);
    int sh, sum;
    sh = $signed(acc) >>> 8;
    sum = sh + int'($signed(b));
    if (sum > 32767) sum = 32767;
    if (sum < 0) sum = 0;
    return 16'(sum);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic do_reset();
    acc_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst bias_addr", bias_addr, 0);
    check("rst max_valid", max_valid, 0);
    check("rst out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_idx = 0;
    m_valid = 0; m_last = 0; m_fd = 0; m_data = '0; m_idx = 0;
    m_max_valid = 0; m_max_idx = 0;
  endtask

  task automatic cycle(input logic v, input logic [31:0] acc, input logic rdy);
    logic rd, hs;
    int best;
    acc_valid = v;
    acc_data = acc;
    out_ready = rdy;
    #1;
    rd = !m_valid || rdy;
    hs = m_valid && rdy;
    check("acc_ready", acc_ready, rd);
    check("bias_addr", bias_addr, 32'(exp_idx));
    m_fd = hs && m_last;
    if (v && rd) begin
      m_data = ref_act(acc, bias_mem[exp_idx]);
      m_idx = exp_idx;
      m_last = exp_idx == 14;
      m_valid = 1;
      fr[exp_idx] = int'(m_data);
`ifdef ARGMAX_EN
      if (exp_idx == 14) begin
        best = 0;
        for (int i = 1; i < 15; i++) if (fr[i] > fr[best]) best = i;
        m_max_idx = best;
        m_max_valid = 1;
      end else if (exp_idx == 0) m_max_valid = 0;
`endif
      exp_idx = (exp_idx == 14) ? 0 : exp_idx + 1;
    end else if (hs) m_valid = 0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_idx", out_idx, 32'(m_idx));
    check("out_last", out_last, m_last);
    check("frame_done", frame_done, m_fd);
    check("max_idx", max_idx, 32'(m_max_idx));
    check("max_valid", max_valid, m_max_valid);
  endtask

  initial begin
    logic [15:0] hold;
    logic [31:0] r;
    int fd_cnt, held_idx;
    vecs = '{
      '{32'h0000_0500, 16'h0010, 16'h0015},
      '{32'h7fff_ff00, 16'h0000, 16'h7fff},
      '{32'hffff_f000, 16'h0001, 16'h0000},
      '{32'h0000_0100, 16'hffff, 16'h0000},
      '{32'hffff_8000, 16'h0100, 16'h0080},
      '{32'h007f_ff00, 16'h0001, 16'h7fff},
      '{32'h007f_fe00, 16'h0001, 16'h7fff},
      '{32'h0000_00ff, 16'h0005, 16'h0005},
      '{32'h8000_0000, 16'h7fff, 16'h0000},
      '{32'h0000_0000, 16'h8000, 16'h0000},
      '{32'hffff_ff00, 16'h0003, 16'h0002},
      '{32'h0000_1234, 16'h7ff0, 16'h7fff}
    };
    for (int i = 0; i < 15; i++) bias_mem[i] = '0;
    for (int i = 0; i < 15; i++) fr[i] = 0;
    do_reset();
    check("idle acc_ready", acc_ready, 1);
    check("idle frame_done", frame_done, 0);
    check("idle out_idx", out_idx, 0);
    check("idle out_last", out_last, 0);
    check("idle max_idx", max_idx, 0);
    for (int i = 0; i < 12; i++) begin
      bias_mem[exp_idx] = vecs[i].bias;
      cycle(1'b1, vecs[i].acc, 1'b1);
      check("vec out_data", out_data, vecs[i].exp);
    end
    cycle(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 15; i++) bias_mem[i] = 16'(i * 3);
    fd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'(i) << 8, 1'b1);
      fd_cnt += int'(frame_done);
    end
    check("16th out_idx", out_idx, 0);
    cycle(1'b0, '0, 1'b1);
    fd_cnt += int'(frame_done);
    check("frame_done count", 32'(fd_cnt), 1);
    cycle(1'b1, 32'h0000_4200, 1'b1);
    hold = out_data;
    held_idx = exp_idx;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h0000_0900, 1'b0);
      check("held out_data", out_data, hold);
      check("held idx", bias_addr, 32'(held_idx));
    end
    cycle(1'b1, 32'h0000_0900, 1'b1);
    check("resume out_idx", out_idx, 32'(held_idx));
    cycle(1'b0, '0, 1'b1);
`ifdef ARGMAX_EN
    do_reset();
    for (int i = 0; i < 15; i++) bias_mem[i] = '0;
    for (int i = 0; i < 15; i++)
      cycle(1'b1, (i == 3 || i == 9) ? 32'd1000 << 8 : 32'(10 * i) << 8, 1'b1);
    check("argmax idx", max_idx, 3);
    check("argmax valid", max_valid, 1);
    cycle(1'b1, 32'h0000_0100, 1'b1);
    check("argmax clear", max_valid, 0);
    cycle(1'b1, 32'h0000_0200, 1'b1);
    do_reset();
    check("mid rst idx", bias_addr, 0);
`endif
    for (int i = 0; i < 15; i++) bias_mem[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, 1) ? r : {{12{r[19]}}, r[19:0]},
            1'($urandom_range(0, 2) != 0));
      if (i % 97 == 96) for (int j = 0; j < 15; j++) bias_mem[j] = 16'($urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
